// File: rtl/n_bit_bcd_display_if.sv
// rtl/n_bit_bcd_display_if.sv - display register read/convert/scan bundle
interface n_bit_bcd_display_if #(
  parameter int N      = 32,
  parameter int DIGITS = 10
);
  localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [N-1:0]          rd;
  logic                  load;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic                  busy;
  logic                  done;
  logic [SEL_W-1:0]      digit_sel;
  logic [3:0]            digit;
  logic                  blank;

  modport master (
    output rd, load,
    input  bcd, neg, busy, done, digit_sel, digit, blank
  );

  modport slave (
    input  rd, load,
    output bcd, neg, busy, done, digit_sel, digit, blank
  );
endinterface

// File: rtl/n_bit_bcd_display.sv
// rtl/n_bit_bcd_display.sv - sequential double-dabble binary->BCD with scanned digit output
// Optional signed operands via N_BIT_BCD_SIGNED_EN.
module n_bit_bcd_display #(
  parameter int N        = 32,
  parameter int DIGITS   = 10,
  parameter int SCAN_DIV = 4
) (
  input logic               clk,
  input logic               reset,
  n_bit_bcd_display_if.slave bus
);
  localparam int BW    = 4 * DIGITS;
  localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW    = $clog2(N + 1);
  localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t            state_q;
  logic [N-1:0]      shift_q;
  logic [BW-1:0]     scratch_q;
  logic [BW-1:0]     bcd_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_pend_q;
  logic              neg_q;
  logic              done_q;
  logic [PW-1:0]     presc_q;
  logic [SEL_W-1:0]  sel_q;

  logic [N-1:0]      op_d;
  logic              neg_load_d;
  logic [BW-1:0]     adj_d;
  logic [SEL_W-1:0]  msd_d;
  logic [3:0]        digit_d;

`ifdef N_BIT_BCD_SIGNED_EN
  // Magnitude as unsigned N bits, so the most negative value converts exactly.
  always_comb begin
    neg_load_d = bus.rd[N-1];
    op_d       = bus.rd[N-1] ? (~bus.rd + 1'b1) : bus.rd;
  end
`else
  always_comb begin
    neg_load_d = 1'b0;
    op_d       = bus.rd;
  end
`endif

  always_comb begin
    adj_d = scratch_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        adj_d[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      neg_pend_q <= 1'b0;
      neg_q      <= 1'b0;
      done_q     <= 1'b0;
      presc_q    <= '0;
      sel_q      <= '0;
    end else begin
      done_q <= 1'b0;

      if (presc_q == PW'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        sel_q   <= (sel_q == SEL_W'(DIGITS - 1)) ? '0 : sel_q + 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end

      // A load in any state restarts; an aborted run never reaches LATCH.
      if (bus.load) begin
        shift_q    <= op_d;
        scratch_q  <= '0;
        cnt_q      <= CW'(N);
        neg_pend_q <= neg_load_d;
        state_q    <= SHIFT;
      end else begin
        case (state_q)
          IDLE: ;
          SHIFT: begin
            scratch_q <= {adj_d[BW-2:0], shift_q[N-1]};
            shift_q   <= shift_q << 1;
            cnt_q     <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
              state_q <= LATCH;
            end
          end
          LATCH: begin
            bcd_q   <= scratch_q;
            neg_q   <= neg_pend_q;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Scan output reads only the latched result; digit 0 is never blanked.
  always_comb begin
    msd_d   = '0;
    digit_d = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] != 4'd0) begin
        msd_d = SEL_W'(k);
      end
      if (sel_q == SEL_W'(k)) begin
        digit_d = bcd_q[4*k +: 4];
      end
    end
  end

  assign bus.bcd       = bcd_q;
  assign bus.neg       = neg_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.digit_sel = sel_q;
  assign bus.digit     = digit_d;
  assign bus.blank     = (sel_q > msd_d);
endmodule

// File: tb/tb_n_bit_bcd_display.sv
// tb/tb_n_bit_bcd_display.sv - self-checking bench for n_bit_bcd_display
module tb_n_bit_bcd_display;
  localparam int N        = 32;
  localparam int DIGITS   = 10;
  localparam int SCAN_DIV = 4;
`ifdef N_BIT_BCD_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  n_bit_bcd_display_if #(.N(N), .DIGITS(DIGITS)) bus ();

  n_bit_bcd_display #(.N(N), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  longint unsigned cyc     = 0;
  longint unsigned exp_val = 0;
  bit              exp_neg = 1'b0;

  function automatic longint unsigned p10(input int k);
    longint unsigned r = 1;
    repeat (k) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input longint unsigned v);
    logic [4*DIGITS-1:0] r = '0;
    longint unsigned t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic longint unsigned magnitude(input logic [N-1:0] v);
    if (SIGNED && v[N-1]) return (64'd1 << N) - longint'(v);
    return longint'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) cyc = 0;
    else cyc = cyc + 1;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_scan();
    int s;
    s = int'((cyc / SCAN_DIV) % DIGITS);
    chk("digit_sel", 64'(bus.digit_sel), 64'(s));
    chk("digit", 64'(bus.digit), 64'((exp_val / p10(s)) % 10));
    chk("blank", 64'(bus.blank), 64'(s > 0 && exp_val < p10(s)));
  endtask

  task automatic start(input logic [N-1:0] v);
    bus.rd   = v;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    chk("busy_after_load", 64'(bus.busy), 64'd1);
  endtask

  task automatic finish_conv(input logic [N-1:0] v);
    for (int i = 1; i <= N; i++) begin
      tick();
      chk("busy_shift", 64'(bus.busy), 64'd1);
      chk("done_early", 64'(bus.done), 64'd0);
      chk("bcd_held", 64'(bus.bcd), 64'(to_bcd(exp_val)));
    end
    tick();
    exp_val = magnitude(v);
    exp_neg = SIGNED && v[N-1];
    chk("done", 64'(bus.done), 64'd1);
    chk("busy_idle", 64'(bus.busy), 64'd0);
    chk("bcd", 64'(bus.bcd), 64'(to_bcd(exp_val)));
    chk("neg", 64'(bus.neg), 64'(exp_neg));
    chk_scan();
    tick();
    chk("done_pulse", 64'(bus.done), 64'd0);
  endtask

  task automatic convert(input logic [N-1:0] v);
    start(v);
    finish_conv(v);
  endtask

  initial begin
    bus.rd   = '0;
    bus.load = 1'b0;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_bcd", 64'(bus.bcd), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_neg", 64'(bus.neg), 64'd0);
    chk("rst_sel", 64'(bus.digit_sel), 64'd0);
    chk("rst_digit", 64'(bus.digit), 64'd0);
    chk("rst_blank", 64'(bus.blank), 64'd0);

    convert(32'd1234567890);
    chk("bcd_const", 64'(bus.bcd), 64'h12_3456_7890);
    convert(32'hFFFF_FFFF);
    chk("bcd_ffff", 64'(bus.bcd), SIGNED ? 64'h1 : 64'h42_9496_7295);
    convert(32'h8000_0000);
    chk("bcd_8000", 64'(bus.bcd), 64'h21_4748_3648);

    // Restart: load 99 at edge 0, load 7 at edge 10, single done at edge 43.
    start(32'd99);
    repeat (9) begin
      tick();
      chk("abort_done", 64'(bus.done), 64'd0);
      chk("abort_bcd", 64'(bus.bcd), 64'(to_bcd(exp_val)));
    end
    start(32'd7);
    finish_conv(32'd7);
    chk("bcd_7", 64'(bus.bcd), 64'h7);

    convert(32'd42);
    repeat (45) begin
      tick();
      chk_scan();
    end
    convert(32'd0);
    repeat (45) begin
      tick();
      chk_scan();
    end

    repeat (6) convert(N'($urandom));

    // Reset at edge 15 of a conversion.
    start(N'($urandom));
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_val = 0;
    exp_neg = 1'b0;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_bcd", 64'(bus.bcd), 64'd0);
    chk_scan();
    repeat (40) begin
      tick();
      chk("post_rst_done", 64'(bus.done), 64'd0);
      chk_scan();
    end
    convert(32'd305419896);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/n_bit_bcd_display.md
# n_bit_bcd_display

Reader for the calculator's display register: takes the N-bit binary value held in `rd` and converts it to packed BCD digits with a sequential double-dabble engine (one shift per clock). It then time-multiplexes the digits onto a single-digit output for a scanned seven-segment display. It sits between the memory block's `rd` output and the board's digit/anode drivers. `load` is driven by the controller one cycle after it asserts the display write enable.

## Interface
- `N`, default 32: width of the binary input.
- `DIGITS`, default 10: number of BCD digits produced. Must be ≥ the decimal digit count of 2^N−1; upper digits beyond `DIGITS` are truncated.
- `SCAN_DIV`, default 4: clocks each digit is held on the scan output; minimum 1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `rd` in N: binary value to display; sampled only on `load`.
- `load` in 1: start a conversion of `rd`.
- `bcd` out 4*DIGITS: converted result; digit k is `bcd[4k+3:4k]`, where k=0 is the least significant digit.
- `neg` out 1: result is negative (signed builds only).
- `busy` out 1: conversion in progress.
- `done` out 1: one-cycle pulse when `bcd`/`neg` update.
- `digit_sel` out $clog2(DIGITS): index of the digit currently scanned.
- `digit` out 4: `bcd` nibble at `digit_sel`.
- `blank` out 1: the scanned digit is a leading zero.

## Operation
- FSM states: IDLE, SHIFT, LATCH.
- IDLE: on `load`, capture the operand into the shift register, clear the BCD scratch, set the iteration counter to N, and go to SHIFT.
- SHIFT: each cycle, add 3 to every scratch digit ≥5, then shift {scratch, operand} left by 1 and decrement the counter. When the counter reaches 0, go to LATCH.
- LATCH: copy scratch to `bcd`, latch `neg`, pulse `done`, and return to IDLE.
- `load` in SHIFT or LATCH restarts the conversion with the new `rd`. The aborted conversion produces no `done`, and `bcd` keeps its previous value.
- `busy` = state is not IDLE.
- Scan: a prescaler counts 0..SCAN_DIV−1. On wrap, `digit_sel` increments, going from DIGITS−1 back to 0.
- Scan runs continuously and independently of conversion. `digit`/`blank` reflect the latched `bcd` only, never the scratch.
- `blank` = 1 when `digit_sel` > index of the most significant nonzero digit of `bcd`. Digit 0 is never blanked, so a value of 0 shows "0".
- Reset values: `bcd`=0, `neg`=0, `busy`=0, `done`=0, `digit_sel`=0, prescaler=0, state=IDLE. Reset has priority over `load` and aborts any conversion.

## Timing
- Edge 0: `load` sampled; `busy`=1 after edge 0.
- Edges 1..N: one shift iteration each.
- Edge N+1: `bcd`, `neg` and `done`=1 visible; `busy`=0.
- Latency from load edge to `done` = N+1 cycles (33 for N=32).
- `load` on the edge where `done` is high is accepted: `busy`=1 again on the next cycle, with no idle gap.
- `done` is high for exactly one cycle per completed conversion.
- `digit`/`blank` are combinational from `digit_sel` and `bcd`. A `bcd` update is visible on the scan output in the same cycle as `done`.
- With SCAN_DIV=1, `digit_sel` advances every clock.

## Configuration
- `N_BIT_BCD_SIGNED_EN` defined:
  - On load, if `rd[N-1]`=1, operand = two's-complement negation of `rd` (magnitude as unsigned N bits, so −2^(N−1) converts correctly), and `neg` is latched as 1 at LATCH.
  - Otherwise `neg` is latched as 0.
- Not defined:
  - `rd` is treated as unsigned.
  - `neg` is constant 0.
  - No negation logic is present.

## Test plan
1. Assert `reset` for 2 cycles, then release -> `bcd`=0, `busy`=0, `done`=0, `digit_sel`=0, `digit`=0, `blank`=0.
2. N=32, load `rd`=1234567890 -> `done` 33 cycles later, `bcd`=40'h1234567890, `busy` high for cycles 1–32.
3. Load `rd`=32'hFFFFFFFF:
   - Unsigned build -> `bcd`=40'h4294967295, `neg`=0.
   - Signed build -> `bcd`=1, `neg`=1.
   - Signed build, `rd`=32'h80000000 -> `bcd`=40'h2147483648, `neg`=1.
4. Load 99 at cycle 0, load 7 at cycle 10 -> exactly one `done`, at cycle 43, with `bcd`=7. The previous `bcd` is held until then.
5. With `bcd`=42 and SCAN_DIV=4:
   - `digit_sel` steps 0..9, holding each value 4 cycles, then wraps to 0.
   - `digit`=2,4,0,...; `blank`=0 for indices 0–1, 1 for 2–9.
   - After loading 0, index 0 shows `digit`=0 with `blank`=0.
6. Assert `reset` at cycle 15 of a conversion -> next cycle `busy`=0, no `done`, `bcd`=0. A new load then completes normally.
